conv_layer_par: RTL and testbench
=================================

CONV_LAYER_PAR -- requirements
Module: conv_layer_par

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, sample width (signed, two's complement); D, 1, image/filter depth; H, 8, image height; W, 8, image width; F, 3, filter size; K, 6, filter count; P, 2, parallel MAC lanes (1..K); FRAC, 0, accumulator right-shift before output.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a layer.
REQ-005 image  input  D*H*W*DATA_WIDTH  flat image, MSB-first, order [d][row][col].
REQ-006 filters  input  K*D*F*F*DATA_WIDTH  flat filters, order [k][d][r][c].
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the last output handshake.
REQ-009 out_valid  output  1  out_data holds a valid result group.
REQ-010 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-011 out_data  output  P*DATA_WIDTH  lane p result at slice p (lane 0 most significant).
REQ-012 out_group  output  $clog2(ceil(K/P))+1  filter group index (first filter = out_group*P).
REQ-013 out_row / out_col  output  $clog2(H)+1 each  output pixel coordinates.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, MAC, OUT, DONE; IDLE->LOAD on start; LOAD->MAC; MAC->OUT after D*F*F accumulate cycles; OUT->MAC on handshake (next pixel); OUT->LOAD on handshake of the last pixel of a group when more groups remain; OUT->DONE on handshake of the last pixel of the last group; DONE->IDLE unconditionally.
REQ-015 On accepted start, image and filters SHALL be latched; later input changes SHALL NOT affect the layer.
REQ-016 start while busy SHALL be ignored.
REQ-017 LOAD SHALL select filters group*P .. group*P+P-1; lanes whose index is >= K SHALL output zero.
REQ-018 Pixels SHALL be produced in row-major order, (H-F+1)*(W-F+1) per group, groups ascending.
REQ-019 Each lane SHALL accumulate signed products at width 2*DATA_WIDTH+$clog2(D*F*F) without overflow.
REQ-020 Output SHALL be acc arithmetically shifted right by FRAC, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 Latency from entering MAC to out_valid SHALL be exactly D*F*F+1 cycles.
REQ-022 out_data/out_group/out_row/out_col SHALL be stable while out_valid && !out_ready.
REQ-023 Back-to-back: start in the done cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-024 reset SHALL force state IDLE and busy, done, out_valid, out_data, out_group, out_row, out_col and all accumulators to 0, including mid-layer; no done pulse results.

Configuration
REQ-025 With RELU_EN defined, negative saturated results SHALL be output as 0; without it, signed saturated results SHALL pass unchanged.

Structure
REQ-026 Package conv_pkg SHALL hold the FSM state enum, the accumulator-width function and the saturate function.
REQ-027 Sub-module conv_mac_lane (one per lane: clear, enable, pixel, weight, acc out) SHALL be instantiated P times.

Verification
REQ-028 Image all 1, filters all 1, D=1, K=6, P=2: 3 groups x 36 outputs, every value 9, done once after 108th handshake.
REQ-029 Image pixel 100, weight 100 (DATA_WIDTH=8): output saturates to 127; weight -100 yields -128, or 0 with RELU_EN.
REQ-030 K=5, P=2: group 2 lane 1 outputs 0 for all 36 pixels; out_group sequence 0,1,2.
REQ-031 out_ready low for 10 cycles at pixel (2,3): out_valid held, out_data/out_row/out_col unchanged, no pixel dropped.
REQ-032 reset asserted at group 1 pixel 5: next cycle all outputs 0, state IDLE; fresh start reproduces full-layer results.
REQ-033 start pulsed while busy and image changed after start: results match the originally latched image.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type, accumulator width and saturation helpers
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one signed multiply-accumulate lane with synchronous clear
module conv_mac_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int AW = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] pixel,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic signed [AW-1:0]         acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = pixel * weight;
  always_ff @(posedge clk)
    if (reset || clear) acc <= '0;
    else if (en) acc <= acc + AW'(prod);
endmodule

// File: rtl/conv_layer_par.sv
// conv_layer_par: P-lane convolution layer with valid/ready output; define RELU_EN to clamp negatives to 0
module conv_layer_par
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int D = 1,
  parameter int H = 8,
  parameter int W = 8,
  parameter int F = 3,
  parameter int K = 6,
  parameter int P = 2,
  parameter int FRAC = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [D*H*W*DATA_WIDTH-1:0]        image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]      filters,
  output logic                               busy,
  output logic                               done,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [P*DATA_WIDTH-1:0]            out_data,
  output logic [$clog2((K+P-1)/P):0]         out_group,
  output logic [$clog2(H):0]                 out_row,
  output logic [$clog2(H):0]                 out_col
);
  localparam int N = D * F * F;
  localparam int NI = D * H * W;
  localparam int NF = K * N;
  localparam int OH = H - F + 1;
  localparam int OW = W - F + 1;
  localparam int NG = (K + P - 1) / P;
  localparam int GW = $clog2(NG) + 1;
  localparam int RW = $clog2(H) + 1;
  localparam int MW = $clog2(N + 1);
  localparam int IW = $clog2(NI);
  localparam int FW = $clog2(NF);
  localparam int AW = acc_width(DATA_WIDTH, N);
  localparam logic [MW-1:0] M_LAST = MW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
  localparam logic [RW-1:0] C_LAST = RW'(OW - 1);
  localparam logic [GW-1:0] G_LAST = GW'(NG - 1);
  state_t state, next;
  logic [NI*DATA_WIDTH-1:0] img_q;
  logic [NF*DATA_WIDTH-1:0] flt_q;
  logic signed [DATA_WIDTH-1:0] img_a [NI];
  logic signed [DATA_WIDTH-1:0] flt_a [NF];
  logic signed [DATA_WIDTH-1:0] wl [P][N];
  logic signed [DATA_WIDTH-1:0] sat [P];
  logic signed [DATA_WIDTH-1:0] res [P];
  logic signed [DATA_WIDTH-1:0] pixel;
  logic signed [AW-1:0] acc [P];
  logic [MW-1:0] m;
  logic [GW-1:0] grp;
  logic [RW-1:0] row, col;
  logic hs, last_pix, last_grp, clr;
  for (genvar i = 0; i < NI; i++) begin : g_img
    assign img_a[i] = img_q[(NI-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end
  for (genvar i = 0; i < NF; i++) begin : g_flt
    assign flt_a[i] = flt_q[(NF-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end
  assign hs = out_valid && out_ready;
  assign last_pix = row == R_LAST && col == C_LAST;
  assign last_grp = grp == G_LAST;
  assign clr = state == LOAD || (state == OUT && hs);
  assign busy = state == LOAD || state == MAC || state == OUT;
  assign done = state == DONE;
  assign out_group = grp;
  assign out_row = row;
  assign out_col = col;
  assign pixel = img_a[IW'(((int'(m) / (F * F)) * H + int'(row) + int'(m) / F % F) * W + int'(col) + int'(m) % F)];
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? LOAD : IDLE) :
           state == LOAD ? MAC :
           state == MAC  ? (m == M_LAST ? OUT : MAC) :
           state == OUT  ? (!hs ? OUT : !last_pix ? MAC : last_grp ? DONE : LOAD) :
           IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk)
    for (int p = 0; p < P; p++)
      for (int j = 0; j < N; j++)
        if (reset) wl[p][j] <= '0;
        else if (state == LOAD) wl[p][j] <= int'(grp) * P + p < K ? flt_a[FW'((int'(grp) * P + p) * N + j)] : '0;
  for (genvar p = 0; p < P; p++) begin : g_lane
    conv_mac_lane #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_lane (
      .clk(clk), .reset(reset), .clear(clr), .en(state == MAC),
      .pixel(pixel), .weight(wl[p][m]), .acc(acc[p])
    );
    assign sat[p] = DATA_WIDTH'(saturate(64'(acc[p]) >>> FRAC, DATA_WIDTH));
`ifdef RELU_EN
    assign res[p] = sat[p][DATA_WIDTH-1] ? '0 : sat[p];
`else
    assign res[p] = sat[p];
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      img_q <= '0;
      flt_q <= '0;
      m <= '0;
      grp <= '0;
      row <= '0;
      col <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        img_q <= image;
        flt_q <= filters;
        grp <= '0;
        row <= '0;
        col <= '0;
      end
      m <= state == MAC ? m + 1'b1 : '0;
      if (state == OUT && !out_valid) begin
        out_valid <= 1'b1;
        for (int p = 0; p < P; p++) out_data[(P-1-p)*DATA_WIDTH +: DATA_WIDTH] <= res[p];
      end else if (hs) begin
        out_valid <= 1'b0;
        col <= col == C_LAST ? '0 : col + 1'b1;
        row <= col == C_LAST ? (row == R_LAST ? '0 : row + 1'b1) : row;
        grp <= last_pix && !last_grp ? grp + 1'b1 : grp;
      end
    end
  end
endmodule

// File: tb/tb_conv_layer_par.sv
// tb_conv_layer_par: scoreboard bench for conv_layer_par (K=6 main instance plus a K=5 instance)
module tb_conv_layer_par;
  typedef struct {logic [15:0] data; int g; int r; int c;} exp_t;
  typedef struct {logic signed [7:0] px; logic signed [7:0] wt; logic signed [7:0] ex;} vec_t;
  logic clk = 0, reset = 1, start = 0, out_ready = 1, with5 = 0;
  logic [511:0] image = '0;
  logic [431:0] filters = '0;
  logic busy, done, out_valid, busy5, done5, out_valid5;
  logic [15:0] out_data, out_data5;
  logic [2:0] out_group, out_group5;
  logic [3:0] out_row, out_col, out_row5, out_col5;
  logic signed [7:0] im [64];
  logic signed [7:0] fl [6][9];
  exp_t sb[$], sb5[$];
  int n_chk = 0, n_bad = 0, hs, hs5, dn, dn5;
  always #5 clk = ~clk;
  conv_layer_par dut (
    .clk(clk), .reset(reset), .start(start), .image(image), .filters(filters),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_group(out_group), .out_row(out_row), .out_col(out_col)
  );
  conv_layer_par #(.K(5)) dut5 (
    .clk(clk), .reset(reset), .start(start && with5), .image(image), .filters(filters[431:72]),
    .busy(busy5), .done(done5), .out_valid(out_valid5), .out_ready(1'b1),
    .out_data(out_data5), .out_group(out_group5), .out_row(out_row5), .out_col(out_col5)
  );
  task automatic check(input string name, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  function automatic logic signed [7:0] model(input int k, input int kk, input int r, input int c);
    longint s = 0;
    if (k >= kk) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += longint'(im[(r+i)*8+c+j]) * longint'(fl[k][i*3+j]);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s);
  endfunction
  task automatic pack();
    for (int i = 0; i < 64; i++) image[(63-i)*8 +: 8] = im[i];
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 9; j++) filters[(53-(k*9+j))*8 +: 8] = fl[k][j];
  endtask
  task automatic fill(input logic signed [7:0] px, input logic signed [7:0] wt);
    for (int i = 0; i < 64; i++) im[i] = px;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 9; j++) fl[k][j] = wt;
    pack();
  endtask
  task automatic push_table(input logic signed [7:0] ex);
    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) sb.push_back('{{ex, ex}, g, r, c});
  endtask
  task automatic push_model(input bit five);
    exp_t e;
    for (int g = 0; g < 3; g++)
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          e = '{{model(g*2, five ? 5 : 6, r, c), model(g*2+1, five ? 5 : 6, r, c)}, g, r, c};
          if (five) sb5.push_back(e);
          else sb.push_back(e);
        end
  endtask
  task automatic run_layer(input bit stall, input bit rst_mid, input bit restart, input bit b2b);
    int cyc = 0, lat = 1;
    bit seen = 0, stalled = 0;
    exp_t e;
    hs = 0; hs5 = 0; dn = 0; dn5 = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    while (cyc < 6000) begin
      start = restart && lat == 3;
      if (restart && lat == 3) begin
        for (int i = 0; i < 64; i++) im[i] = 8'(i % 13 - 6);
        pack();
      end
      if (!seen && out_valid) begin
        seen = 1;
        check("first_latency", lat, 12);
      end
      if (stall && !stalled && out_valid && out_group == 0 && out_row == 2 && out_col == 3) begin
        stalled = 1;
        out_ready = 0;
        for (int s = 0; s < 10; s++) begin
          @(posedge clk); #1;
          cyc++;
          check("stall_hold", {out_valid, out_data, out_group, out_row, out_col}, {1'b1, sb[0].data, 3'd0, 4'd2, 4'd3});
        end
        out_ready = 1;
      end
      if (rst_mid && out_valid && out_group == 1 && out_row == 0 && out_col == 5) begin
        out_ready = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("reset_mid", {busy, done, out_valid, out_data, out_group, out_row, out_col}, 0);
        repeat (3) begin
          @(posedge clk); #1;
          check("no_done_after_reset", {busy, done, out_valid}, 0);
        end
        sb.delete();
        out_ready = 1;
        return;
      end
      if (out_valid && out_ready) begin
        check("out_avail", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_main", {out_data, out_group, out_row, out_col}, {e.data, 3'(e.g), 4'(e.r), 4'(e.c)});
        end
        hs++;
      end
      if (out_valid5) begin
        check("out5_avail", sb5.size() > 0, 1);
        if (sb5.size() > 0) begin
          e = sb5.pop_front();
          check("out_k5", {out_data5, out_group5, out_row5, out_col5}, {e.data, 3'(e.g), 4'(e.r), 4'(e.c)});
        end
        hs5++;
      end
      if (done5) dn5++;
      if (done) begin
        dn++;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      lat++;
    end
    check("layer_timeout", cyc < 6000, 1);
    check("handshakes_before_done", hs, 108);
    check("sb_empty_at_done", sb.size(), 0);
    if (b2b) begin
      start = 1;
      @(posedge clk); #1;
      start = 0;
      check("start_in_done_ignored", {busy, done, out_valid}, 0);
    end else begin
      @(posedge clk); #1;
      check("done_pulse_width", {busy, done}, 0);
    end
  endtask
  initial begin
    vec_t tbl [8];
    logic signed [7:0] ex;
    tbl = '{'{1, 1, 9}, '{100, 100, 127}, '{100, -100, -128}, '{-2, 3, -54},
            '{0, 77, 0}, '{10, -1, -90}, '{3, 4, 108}, '{5, 3, 127}};
    fill(0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    check("reset_state", {busy, done, out_valid, out_data, out_group, out_row, out_col}, 0);
    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].px, tbl[i].wt);
      ex = tbl[i].ex;
`ifdef RELU_EN
      if (ex < 0) ex = 0;
`endif
      push_table(ex);
      with5 = i == 0;
      if (with5) push_model(1);
      run_layer(i == 2, 0, 0, i == 7);
      if (with5) begin
        check("k5_handshakes", hs5, 108);
        check("k5_sb_empty", sb5.size(), 0);
        check("k5_done_once", dn5, 1);
      end
      with5 = 0;
    end
    for (int i = 0; i < 64; i++) im[i] = 8'(int'($urandom_range(0, 15)) - 8);
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 9; j++) fl[k][j] = 8'(int'($urandom_range(0, 15)) - 8);
    pack();
    push_model(0);
    run_layer(0, 0, 1, 0);
    fill(1, 1);
    push_table(9);
    run_layer(0, 1, 0, 0);
    push_model(0);
    run_layer(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
